// File: rtl/i2c_host_pkg.sv
// Shared states, phases and constants for the single-master I2C register controller.
package i2c_host_pkg;
  localparam int   QTR_PER_BIT   = 4;
  localparam int   BITS_PER_BYTE = 8;
  localparam logic I2C_RD        = 1'b1;
  localparam logic I2C_WR        = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BYTE, ST_ACK, ST_RSTART, ST_STOP, ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_DEV_W, PH_REG, PH_WDATA, PH_DEV_R, PH_RDATA
  } phase_t;
endpackage

// File: rtl/i2c_host_tick.sv
// Quarter-bit tick: CLK_DIV cycles per quarter, 2-bit quarter index and end-of-quarter strobe.
// i_hold freezes the count (clock stretching); dropping i_run rewinds to Q0.
module i2c_host_tick
  import i2c_host_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_hold,
  output logic [1:0] o_qtr,
  output logic       o_qtr_end
);
  localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [1:0]     LAST_QTR = 2'(QTR_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_qtr;
  logic          w_end;

  assign w_end     = i_run && !i_hold && (r_cnt == LAST_CNT);
  assign o_qtr     = r_qtr;
  assign o_qtr_end = w_end;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_cnt <= '0;
      r_qtr <= 2'd0;
    end else if (w_end) begin
      r_cnt <= '0;
      r_qtr <= (r_qtr == LAST_QTR) ? 2'd0 : r_qtr + 2'd1;
    end else if (!i_hold) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_host_ctrl.sv
// Single-master I2C register controller: one request -> START/addr/reg/[RSTART]/data/STOP, one rsp_valid pulse.
// Optional SCL clock stretching is compiled in with I2C_HOST_CLK_STRETCH_EN.
module i2c_host_ctrl
  import i2c_host_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [6:0] DEV_ADR = 7'h11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rw,
  input  logic [7:0] i_req_reg_adr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic       o_scl_oe,
  input  logic       i_scl,
  output logic       o_sda_oe,
  input  logic       i_sda
);
  state_t     r_state, w_state_nxt;
  phase_t     r_phase;
  logic [7:0] r_shift, r_reg_adr, r_wdata, r_rsp_rdata;
  logic [2:0] r_bitcnt;
  logic       r_rw, r_err, r_nack, r_rsp_valid, r_rsp_err;

  logic [1:0] w_qtr;
  logic       w_qtr_end, w_run, w_hold, w_sample, w_bit_end, w_last_bit;
  logic       w_accept, w_ready, w_client_nack, w_scl_oe, w_sda_oe;

  assign w_run         = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_ready       = (r_state == ST_IDLE) && !r_rsp_valid;
  assign w_accept      = i_req_valid && w_ready;
  assign w_sample      = w_qtr_end && (w_qtr == 2'd2);
  assign w_bit_end     = w_qtr_end && (w_qtr == 2'(QTR_PER_BIT - 1));
  assign w_last_bit    = (r_bitcnt == 3'(BITS_PER_BYTE - 1));
  assign w_client_nack = (r_phase != PH_RDATA) && r_nack;

`ifdef I2C_HOST_CLK_STRETCH_EN
  assign w_hold = w_run && !w_scl_oe && !i_scl;
`else
  // scl_i has no effect without stretching
  assign w_hold = i_scl & 1'b0;
`endif

  i2c_host_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (w_run),
    .i_hold    (w_hold),
    .o_qtr     (w_qtr),
    .o_qtr_end (w_qtr_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
      ST_START:  if (w_bit_end) w_state_nxt = ST_BYTE;
      ST_BYTE:   if (w_bit_end && w_last_bit) w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (w_bit_end) begin
          if (w_client_nack) w_state_nxt = ST_STOP;
          else begin
            case (r_phase)
              PH_DEV_W, PH_DEV_R: w_state_nxt = ST_BYTE;
              PH_REG:             w_state_nxt = (r_rw == I2C_RD) ? ST_RSTART : ST_BYTE;
              default:            w_state_nxt = ST_STOP;
            endcase
          end
        end
      end
      ST_RSTART: if (w_bit_end) w_state_nxt = ST_BYTE;
      ST_STOP:   if (w_bit_end) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Pad drive decoded from state and quarter; SCL is held low in Q0-Q1 of data/ACK bits.
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      ST_START: w_sda_oe = w_qtr[1];
      ST_BYTE: begin
        w_scl_oe = ~w_qtr[1];
        w_sda_oe = (r_phase != PH_RDATA) && !r_shift[7];
      end
      ST_ACK:   w_scl_oe = ~w_qtr[1];
      ST_RSTART: begin
        w_scl_oe = (w_qtr == 2'd0);
        w_sda_oe = w_qtr[1];
      end
      ST_STOP: begin
        w_scl_oe = (w_qtr == 2'd0);
        w_sda_oe = ~w_qtr[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase     <= PH_DEV_W;
      r_shift     <= 8'h00;
      r_reg_adr   <= 8'h00;
      r_wdata     <= 8'h00;
      r_bitcnt    <= 3'd0;
      r_rw        <= I2C_WR;
      r_err       <= 1'b0;
      r_nack      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_rw      <= i_req_rw;
        r_reg_adr <= i_req_reg_adr;
        r_wdata   <= i_req_wdata;
        r_err     <= 1'b0;
      end
      if (w_sample && r_state == ST_BYTE && r_phase == PH_RDATA) r_shift <= {r_shift[6:0], i_sda};
      if (w_sample && r_state == ST_ACK) r_nack <= i_sda;
      if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_phase  <= PH_DEV_W;
            r_shift  <= {DEV_ADR, I2C_WR};
            r_bitcnt <= 3'd0;
          end
          ST_RSTART: begin
            r_phase  <= PH_DEV_R;
            r_shift  <= {DEV_ADR, I2C_RD};
            r_bitcnt <= 3'd0;
          end
          ST_BYTE: begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_phase != PH_RDATA) r_shift <= {r_shift[6:0], 1'b0};
          end
          ST_ACK: begin
            r_bitcnt <= 3'd0;
            if (w_client_nack) r_err <= 1'b1;
            else begin
              case (r_phase)
                PH_DEV_W: begin
                  r_phase <= PH_REG;
                  r_shift <= r_reg_adr;
                end
                PH_REG: if (r_rw == I2C_WR) begin
                  r_phase <= PH_WDATA;
                  r_shift <= r_wdata;
                end
                PH_DEV_R: r_phase <= PH_RDATA;
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
      if (r_state == ST_DONE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= r_err;
        r_rsp_rdata <= (r_rw == I2C_RD && !r_err) ? r_shift : 8'h00;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_scl_oe    = w_scl_oe;
  assign o_sda_oe    = w_sda_oe;
endmodule

// File: tb/tb_i2c_host_ctrl.sv
// Bench: two controllers (DEV_ADR 0x11 and 0x12) share one open-drain bus with a 4-register client at 0x11.
module tb_i2c_host_ctrl;
  localparam int         C_IDLE = 0, C_ADDR = 1, C_REG = 2, C_DATA = 3, C_ACK = 4, C_TX = 5, C_HACK = 6;
  localparam logic [6:0] CLIENT_ADR = 7'h11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic       a_vld = 1'b0, a_rw = 1'b0, a_rdy, a_rv, a_err, a_scl_oe, a_sda_oe;
  logic [7:0] a_reg = 8'h00, a_wd = 8'h00, a_rd;
  logic       b_vld = 1'b0, b_rw = 1'b0, b_rdy, b_rv, b_err, b_scl_oe, b_sda_oe;
  logic [7:0] b_reg = 8'h00, b_wd = 8'h00, b_rd;

  logic       c_drive = 1'b0;
  wire        scl = !(a_scl_oe || b_scl_oe);
  wire        sda = !(a_sda_oe || b_sda_oe || c_drive);

  wire        m_rdy = sel ? b_rdy : a_rdy;
  wire        m_rv  = sel ? b_rv  : a_rv;
  wire        m_err = sel ? b_err : a_err;
  wire  [7:0] m_rd  = sel ? b_rd  : a_rd;

  i2c_host_ctrl #(.CLK_DIV(4), .DEV_ADR(7'h11)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(a_vld), .o_req_ready(a_rdy), .i_req_rw(a_rw),
    .i_req_reg_adr(a_reg), .i_req_wdata(a_wd), .o_rsp_valid(a_rv), .o_rsp_rdata(a_rd),
    .o_rsp_err(a_err), .o_scl_oe(a_scl_oe), .i_scl(scl), .o_sda_oe(a_sda_oe), .i_sda(sda));

  i2c_host_ctrl #(.CLK_DIV(4), .DEV_ADR(7'h12)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b_vld), .o_req_ready(b_rdy), .i_req_rw(b_rw),
    .i_req_reg_adr(b_reg), .i_req_wdata(b_wd), .o_rsp_valid(b_rv), .o_rsp_rdata(b_rd),
    .o_rsp_err(b_err), .o_scl_oe(b_scl_oe), .i_scl(scl), .o_sda_oe(b_sda_oe), .i_sda(sda));

  initial forever #5 clk = ~clk;

  // Client model: register-pointer I2C memory, NACKs foreign addresses and registers >= 4.
  logic [7:0] mem [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] c_shift = 8'h00;
  logic [1:0] c_ptr = 2'd0;
  int         c_mode = C_IDLE, c_next = C_IDLE, c_bits = 0, n_stop = 0;

  always @(posedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    if (p_scl && scl && p_sda && !sda) begin
      c_mode  <= C_ADDR;
      c_bits  <= 0;
      c_drive <= 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      c_mode  <= C_IDLE;
      c_drive <= 1'b0;
      n_stop  <= n_stop + 1;
    end else if (!p_scl && scl) begin
      if (c_mode == C_ADDR || c_mode == C_REG || c_mode == C_DATA) begin
        c_shift <= {c_shift[6:0], sda};
        c_bits  <= c_bits + 1;
      end
    end else if (p_scl && !scl) begin
      case (c_mode)
        C_ADDR, C_REG, C_DATA: begin
          if (c_bits == 8) begin
            c_bits <= 0;
            if (c_mode == C_ADDR) begin
              if (c_shift[7:1] == CLIENT_ADR) begin
                c_drive <= 1'b1;
                c_next  <= c_shift[0] ? C_TX : C_REG;
                c_mode  <= C_ACK;
              end else c_mode <= C_IDLE;
            end else if (c_mode == C_REG) begin
              if (c_shift < 8'd4) begin
                c_ptr   <= c_shift[1:0];
                c_drive <= 1'b1;
                c_next  <= C_DATA;
                c_mode  <= C_ACK;
              end else c_mode <= C_IDLE;
            end else begin
              mem[c_ptr] <= c_shift;
              c_ptr      <= c_ptr + 2'd1;
              c_drive    <= 1'b1;
              c_next     <= C_DATA;
              c_mode     <= C_ACK;
            end
          end
        end
        C_ACK: begin
          c_drive <= 1'b0;
          c_bits  <= 0;
          if (c_next == C_TX) begin
            c_shift <= mem[c_ptr];
            c_drive <= !mem[c_ptr][7];
            c_bits  <= 1;
          end
          c_mode <= c_next;
        end
        C_TX: begin
          if (c_bits < 8) begin
            c_drive <= !c_shift[7 - c_bits];
            c_bits  <= c_bits + 1;
          end else begin
            c_drive <= 1'b0;
            c_mode  <= C_HACK;
          end
        end
        C_HACK: c_mode <= C_IDLE;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input bit s, input logic rw, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [7:0] e_rd, input logic e_err, input int e_lat);
    exp_t e;
    int   k;
    bit   got;
    e.rdata = e_rd;
    e.err   = e_err;
    e.lat   = e_lat;
    sb.push_back(e);
    @(negedge clk);
    sel = s;
    check({tag, "_rdy_pre"}, m_rdy, 1);
    if (s) begin
      b_vld = 1'b1; b_rw = rw; b_reg = ra; b_wd = wd;
    end else begin
      a_vld = 1'b1; a_rw = rw; a_reg = ra; a_wd = wd;
    end
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    b_vld = 1'b0;
    check({tag, "_rdy_drop"}, m_rdy, 0);
    k   = 0;
    got = 1'b0;
    while (!got && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      got = m_rv;
    end
    e = sb.pop_front();
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_lat"}, k, e.lat);
    check({tag, "_rdata"}, m_rd, e.rdata);
    check({tag, "_err"}, m_err, e.err);
    @(posedge clk);
    #1;
    check({tag, "_rsp_pulse"}, m_rv, 0);
    check({tag, "_rdy_back"}, m_rdy, 1);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", a_scl_oe, 0);
    check("rst_sda_oe", a_sda_oe, 0);
    check("rst_ready", a_rdy, 1);
    check("rst_rsp_valid", a_rv, 0);
    check("rst_rdata", a_rd, 8'h00);
    check("rst_err", a_err, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    s0 = n_stop;
    run_txn("wr_r2", 1'b0, 1'b0, 8'h02, 8'hA5, 8'h00, 1'b0, 1 + 116 * 4);
    check("wr_r2_mem", mem[2], 8'hA5);
    check("wr_r2_stop", n_stop - s0, 1);

    run_txn("rd_r1", 1'b0, 1'b1, 8'h01, 8'h00, 8'h06, 1'b0, 1 + 156 * 4);

    s0 = n_stop;
    run_txn("wr_nack_reg", 1'b0, 1'b0, 8'h20, 8'h3C, 8'h00, 1'b1, 1 + 80 * 4);
    check("wr_nack_reg_stop", n_stop - s0, 1);

    s0 = n_stop;
    run_txn("rd_nack_dev", 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1 + 44 * 4);
    check("rd_nack_dev_stop", n_stop - s0, 1);

    // Abort a read while the register byte is on the wire.
    @(negedge clk);
    sel   = 1'b0;
    a_vld = 1'b1; a_rw = 1'b1; a_reg = 8'h03; a_wd = 8'h00;
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("abort_busy", a_rdy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl_oe", a_scl_oe, 0);
    check("abort_sda_oe", a_sda_oe, 0);
    check("abort_ready", a_rdy, 1);
    check("abort_rsp_valid", a_rv, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    run_txn("rd_r3", 1'b0, 1'b1, 8'h03, 8'h00, 8'h08, 1'b0, 1 + 156 * 4);
    check("mem2_kept", mem[2], 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_host_ctrl.md
# i2c_host_ctrl

Synthesizable single-master I2C controller that turns one-shot register requests into complete bus transactions toward a memory-mapped I2C client (7-bit device address, 8-bit register address, 8-bit data). It generates all SCL/SDA sequencing: START, repeated START, ACK/NACK handling, and STOP. It sits between a simple valid/ready request port and the open-drain bus pads; the pads are external (`scl = scl_oe ? 0 : z`, same for `sda`).

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period; legal range ≥ 2.
- `DEV_ADR`, default 7'h11: target 7-bit device address.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; a request is accepted when `req_valid && req_ready`.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_reg_adr` in 8: client register address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 8: read data; 0 on write or error.
- `rsp_err` out 1: any client NACK occurred; qualified by `rsp_valid`.
- `scl_oe` out 1: 1 drives SCL low.
- `scl_i` in 1: sampled SCL.
- `sda_oe` out 1: 1 drives SDA low.
- `sda_i` in 1: sampled SDA.

## Operation
- Reset values: `scl_oe`=0, `sda_oe`=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE.
- Request fields are latched on accept. `req_ready` drops the next cycle and rises again the cycle after `rsp_valid`.
- Write sequence: START, {DEV_ADR,0}, ACK, reg_adr, ACK, wdata, ACK, STOP.
- Read sequence: START, {DEV_ADR,0}, ACK, reg_adr, ACK, repeated START, {DEV_ADR,1}, ACK, 8 data bits (host releases SDA), host NACK, STOP.
- Main FSM: IDLE → START → BYTE → ACK → (BYTE | RSTART | STOP) → DONE → IDLE.
- A phase register (DEV_W, REG, WDATA, DEV_R, RDATA) selects the byte source and the ACK-slot direction.
- Bytes are MSB first; an 8-bit shift register serves both transmit and receive.
- A client NACK (`sda_i`=1) in any client ACK slot goes straight to STOP. The result is `rsp_err`=1 and `rsp_rdata`=0.
- Reset mid-transaction: on the next edge, both OE outputs are released and the FSM returns to IDLE. No STOP is issued. The next transaction's START resynchronizes the client.

## Timing
- Each bit is 4 quarters (Q0–Q3); each quarter lasts `CLK_DIV` cycles.
- Data bit:
  - Q0: SCL low; SDA updated at the start of Q0.
  - Q1: SCL low.
  - Q2–Q3: SCL released.
  - `sda_i` is sampled on the last cycle of Q2.
- START: SDA high with SCL high for Q0–Q1, SDA low in Q2–Q3; SCL is pulled low at the next bit's Q0.
- RSTART: Q0 SDA released with SCL low; Q1 SCL released; Q2–Q3 SDA low with SCL high.
- STOP: Q0 SDA low with SCL low; Q1 SCL released; Q2–Q3 SDA released.
- Quarter counts: byte+ACK = 36.
  - Write = 116.
  - Read = 156.
  - Device-address NACK = 44.
  - Register-address NACK = 80.
- Latency: accept at edge N; the first quarter starts at N+1; `rsp_valid` is asserted at cycle N+1+quarters×`CLK_DIV` (no stretching).

## Configuration
- `I2C_HOST_CLK_STRETCH_EN` defined: in every quarter where SCL is released, the quarter counter holds until `scl_i`=1 is sampled. Latency grows by the stretch duration.
- Undefined: `scl_i` is ignored and timing is exact as stated above.

## Structure
- Package `i2c_host_pkg`:
  - state enum and phase enum;
  - `QTR_PER_BIT`=4, `BITS_PER_BYTE`=8;
  - `I2C_RD`=1'b1, `I2C_WR`=1'b0.
- Sub-module `i2c_host_tick`: quarter-tick generator. It has a `CLK_DIV` counter, an enable/hold input for stretching, and emits a 2-bit quarter index plus an end-of-quarter strobe.

## Test plan
- Reset held 3 cycles → `scl_oe`=`sda_oe`=0, `req_ready`=1, `rsp_valid`=0.
- Write reg 0x02, data 0xA5, `CLK_DIV`=4, against the client model → `rsp_valid` at accept+1+464, `rsp_err`=0, client mem[2]=0xA5.
- Read reg 0x01 after reset (client init 05,06,07,08) → `rsp_rdata`=0x06, `rsp_err`=0, `rsp_valid` at accept+1+624.
- Write reg 0x20 → client NACKs the address → `rsp_err`=1, `rsp_rdata`=0, STOP seen, `rsp_valid` at accept+1+320.
- `DEV_ADR`=7'h12 with client at 7'h11, read reg 0 → NACK on first byte, `rsp_err`=1, `rsp_valid` at accept+1+176.
- `rst` pulsed during the REG byte → next cycle OEs=0 and `req_ready`=1; a following read of reg 0x03 returns 0x08.
